// File: rtl/qos_wr_arbiter_pkg.sv
// Shared types and helpers for the QoS write-port arbiter.
// The priority key orders requesters by aging class, then high-bandwidth flag, then QoS level.
package qos_arb_pkg;

  localparam int QOS_HIBW_BIT = 3;
  localparam int AGE_MAX_DEF  = 15;
  localparam int KEY_W        = 5;

  // Field order is the comparison order, so the packed value compares directly.
  typedef struct packed {
    logic       aged;
    logic       hiBw;
    logic [2:0] lvl;
  } qosKey_t;

  function automatic qosKey_t mkKey(input logic aged, input logic [3:0] qos);
    qosKey_t k;
    k.aged = aged;
    k.hiBw = qos[QOS_HIBW_BIT];
    k.lvl  = qos[2:0];
    return k;
  endfunction

endpackage

// File: rtl/qos_wr_arbiter_if.sv
// Requester and write-port bundle for qos_wr_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface qos_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 32,
  parameter int QSIZE = 4
);
  logic [NREQ-1:0]       iReqValid;
  logic [NREQ-1:0]       oReqReady;
  logic [NREQ*DSIZE-1:0] iReqData;
  logic [NREQ*QSIZE-1:0] iReqQoS;
  logic                  iFull;
  logic                  oWr;
  logic [DSIZE-1:0]      oWrData;
  logic [QSIZE-1:0]      oQoS;
  logic [NREQ-1:0]       oGrant;
  logic                  oAged;

  modport slave (
    input  iReqValid, iReqData, iReqQoS, iFull,
    output oReqReady, oWr, oWrData, oQoS, oGrant, oAged
  );

  modport master (
    output iReqValid, iReqData, iReqQoS, iFull,
    input  oReqReady, oWr, oWrData, oQoS, oGrant, oAged
  );
endinterface

// File: rtl/qos_wr_arbiter_rr_pick.sv
// Round-robin one-hot pick among a candidate mask, searching upward from rrPtr with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] cand,
  input  logic [PW-1:0]   rrPtr,
  output logic [NREQ-1:0] win
);
  logic [2*NREQ-1:0] fwd, back;
  logic [NREQ-1:0]   rot, rotWin;

  // Rotate rrPtr down to bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    fwd    = {cand, cand} >> rrPtr;
    rot    = fwd[NREQ-1:0];
    rotWin = rot & (~rot + 1'b1);
    back   = {rotWin, rotWin} << rrPtr;
    win    = back[2*NREQ-1:NREQ];
  end
endmodule

// File: rtl/qos_wr_arbiter.sv
// Shares the QoS FIFO wrapper's single write port among NREQ requesters with
// aging / QoS / round-robin priority; the winner is registered onto the write port.
module qos_wr_arbiter
  import qos_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DSIZE   = 32,
  parameter int QSIZE   = 4,
  parameter int AGE_MAX = AGE_MAX_DEF
) (
  input logic             iClk,
  input logic             iResetn,
  qos_wr_arbiter_if.slave bus
);
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0][AW-1:0] age;
  logic [PW-1:0]           rrPtr;
  logic [PW-1:0]           winIdx;
  logic [NREQ-1:0]         elig, aged, cand, win;
  qosKey_t [NREQ-1:0]      key;
  qosKey_t                 maxKey;
  logic                    xfer;

  always_comb begin
    elig = '0;
    aged = '0;
    key  = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.iReqValid[i] & ~bus.iFull;
      aged[i] = (age[i] == AW'(AGE_MAX));
      key[i]  = mkKey(aged[i], bus.iReqQoS[i*QSIZE +: QSIZE]);
    end
  end

  // Max-key reduction over eligible requesters; ties left for round-robin.
  always_comb begin
    maxKey = '0;
    for (int i = 0; i < NREQ; i++)
      if (elig[i] && (key[i] > maxKey)) maxKey = key[i];
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < NREQ; i++)
      cand[i] = elig[i] && (key[i] == maxKey);
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
    .cand  (cand),
    .rrPtr (rrPtr),
    .win   (win)
  );

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) winIdx = PW'(i);
  end

  assign xfer          = |win;
  assign bus.oReqReady = iResetn ? win : '0;

  // Counters and pointer freeze while downstream is full.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      age   <= '0;
      rrPtr <= '0;
    end else if (!bus.iFull) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.iReqValid[i] || win[i]) age[i] <= '0;
        else if (!aged[i])               age[i] <= age[i] + 1'b1;
      end
      if (xfer) rrPtr <= (winIdx == PW'(NREQ-1)) ? '0 : winIdx + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      bus.oWr     <= 1'b0;
      bus.oWrData <= '0;
      bus.oQoS    <= '0;
      bus.oGrant  <= '0;
      bus.oAged   <= 1'b0;
    end else begin
      bus.oWr    <= xfer;
      bus.oGrant <= win;
      bus.oAged  <= |(win & aged);
      if (xfer) begin
        bus.oWrData <= bus.iReqData[winIdx*DSIZE +: DSIZE];
        bus.oQoS    <= bus.iReqQoS[winIdx*QSIZE +: QSIZE];
      end
    end
  end

  apReadyOneHot: assert property (@(posedge iClk) disable iff (!iResetn) $onehot0(bus.oReqReady));
  apFullBlocks:  assert property (@(posedge iClk) disable iff (!iResetn) bus.iFull |-> (bus.oReqReady == '0));

endmodule

// File: tb/tb_qos_wr_arbiter.sv
// Bench for qos_wr_arbiter: directed scenarios plus a randomized run against a scan-based model.
module tb_qos_wr_arbiter;
  localparam int NREQ    = 4;
  localparam int DSIZE   = 32;
  localparam int QSIZE   = 4;
  localparam int AGE_MAX = 15;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  qos_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .QSIZE(QSIZE)) bus ();

  qos_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .QSIZE(QSIZE), .AGE_MAX(AGE_MAX)) dut (
    .iClk    (clk),
    .iResetn (rstN),
    .bus     (bus)
  );

  logic [NREQ-1:0]  vld;
  logic [DSIZE-1:0] dat [NREQ];
  logic [QSIZE-1:0] qos [NREQ];
  logic             full;

  always_comb begin
    bus.iReqValid = vld;
    bus.iFull     = full;
    bus.iReqData  = '0;
    bus.iReqQoS   = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.iReqData[i*DSIZE +: DSIZE] = dat[i];
      bus.iReqQoS[i*QSIZE +: QSIZE]  = qos[i];
    end
  end

  int nVec = 0;
  int nErr = 0;

  // Reference model: loss counts, search start, expected write register.
  int               mdlAge [NREQ];
  int               mdlRr;
  logic             expWr;
  logic [DSIZE-1:0] expData;
  logic [QSIZE-1:0] expQos;
  logic [NREQ-1:0]  expGrant;
  logic             expAged;

  task automatic mdlReset();
    for (int i = 0; i < NREQ; i++) mdlAge[i] = 0;
    mdlRr = 0; expWr = 0; expData = '0; expQos = '0; expGrant = '0; expAged = 0;
  endtask

  // Scan from the pointer; strictly-greater keeps the first tie found.
  task automatic mdlPick(output int w);
    int best, i, score;
    w = -1; best = -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (mdlRr + k) % NREQ;
      if (vld[i] && !full) begin
        score = ((mdlAge[i] >= AGE_MAX) ? 16 : 0) + int'(qos[i]);
        if (score > best) begin best = score; w = i; end
      end
    end
  endtask

  task automatic mdlCommit(input int w);
    expWr = (w >= 0); expGrant = '0; expAged = 0;
    if (w >= 0) begin
      expData = dat[w]; expQos = qos[w]; expGrant[w] = 1'b1;
      expAged = (mdlAge[w] >= AGE_MAX);
    end
    if (!full) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] || i == w) mdlAge[i] = 0;
        else if (mdlAge[i] < AGE_MAX) mdlAge[i]++;
      end
      if (w >= 0) mdlRr = (w + 1) % NREQ;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    vld = '0; full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin dat[i] = '0; qos[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    mdlReset();
  endtask

  task automatic test_reset();
    rstN = 1'b0; full = 1'b0; vld = '1;
    for (int i = 0; i < NREQ; i++) begin dat[i] = 32'hDEAD0000 + DSIZE'(i); qos[i] = 4'hF; end
    repeat (2) @(posedge clk);
    #1;
    nVec++; if (bus.oWr !== 1'b0)     begin nErr++; $display("FAIL reset_oWr got %0b exp 0", bus.oWr); end
    nVec++; if (bus.oWrData !== '0)   begin nErr++; $display("FAIL reset_oWrData got %h exp 0", bus.oWrData); end
    nVec++; if (bus.oQoS !== '0)      begin nErr++; $display("FAIL reset_oQoS got %h exp 0", bus.oQoS); end
    nVec++; if (bus.oGrant !== '0)    begin nErr++; $display("FAIL reset_oGrant got %b exp 0", bus.oGrant); end
    nVec++; if (bus.oAged !== 1'b0)   begin nErr++; $display("FAIL reset_oAged got %0b exp 0", bus.oAged); end
    nVec++; if (bus.oReqReady !== '0) begin nErr++; $display("FAIL reset_ready got %b exp 0", bus.oReqReady); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    vld = 4'b0001; qos[0] = 4'd2; dat[0] = 32'hA5A50001;
    #1;
    nVec++; if (bus.oReqReady !== 4'b0001) begin nErr++; $display("FAIL single_ready got %b exp 0001", bus.oReqReady); end
    tick(); vld = '0;
    nVec++; if (bus.oWr !== 1'b1)            begin nErr++; $display("FAIL single_oWr got %0b exp 1", bus.oWr); end
    nVec++; if (bus.oWrData !== 32'hA5A50001) begin nErr++; $display("FAIL single_data got %h exp a5a50001", bus.oWrData); end
    nVec++; if (bus.oQoS !== 4'd2)           begin nErr++; $display("FAIL single_qos got %0d exp 2", bus.oQoS); end
    nVec++; if (bus.oGrant !== 4'b0001)      begin nErr++; $display("FAIL single_grant got %b exp 0001", bus.oGrant); end
    nVec++; if (bus.oAged !== 1'b0)          begin nErr++; $display("FAIL single_aged got %0b exp 0", bus.oAged); end
    tick();
    nVec++; if (bus.oWr !== 1'b0)            begin nErr++; $display("FAIL single_idle_oWr got %0b exp 0", bus.oWr); end
    nVec++; if (bus.oWrData !== 32'hA5A50001) begin nErr++; $display("FAIL single_hold_data got %h exp a5a50001", bus.oWrData); end
    nVec++; if (bus.oGrant !== '0)           begin nErr++; $display("FAIL single_idle_grant got %b exp 0", bus.oGrant); end
  endtask

  task automatic test_qos_order();
    int ord [3] = '{2, 1, 0};
    logic [NREQ-1:0] e;
    do_reset();
    qos[0] = 4'd1; qos[1] = 4'd5; qos[2] = 4'd8;
    for (int i = 0; i < 3; i++) dat[i] = 32'h100 + DSIZE'(i);
    vld = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      e = NREQ'(1) << ord[k];
      #1;
      nVec++; if (bus.oReqReady !== e) begin nErr++; $display("FAIL qos_order_ready[%0d] got %b exp %b", k, bus.oReqReady, e); end
      tick(); vld[ord[k]] = 1'b0;
      nVec++; if (bus.oGrant !== e) begin nErr++; $display("FAIL qos_order_grant[%0d] got %b exp %b", k, bus.oGrant, e); end
      nVec++; if (bus.oWrData !== 32'h100 + DSIZE'(ord[k])) begin nErr++; $display("FAIL qos_order_data[%0d] got %h exp %h", k, bus.oWrData, 32'h100 + DSIZE'(ord[k])); end
    end
  endtask

  task automatic test_rr_ties();
    logic [NREQ-1:0] e;
    logic [DSIZE-1:0] d;
    int w;
    do_reset();
    qos[1] = 4'd4; qos[3] = 4'd4; dat[1] = $urandom; dat[3] = $urandom;
    vld = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      w = (k % 2 == 0) ? 1 : 3;
      e = NREQ'(1) << w;
      d = dat[w];
      #1;
      nVec++; if (bus.oReqReady !== e) begin nErr++; $display("FAIL rr_ready[%0d] got %b exp %b", k, bus.oReqReady, e); end
      tick(); dat[w] = $urandom;
      nVec++; if (bus.oGrant !== e)  begin nErr++; $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.oGrant, e); end
      nVec++; if (bus.oWrData !== d) begin nErr++; $display("FAIL rr_data[%0d] got %h exp %h", k, bus.oWrData, d); end
    end
  endtask

  task automatic test_aging();
    logic [NREQ-1:0] e;
    do_reset();
    qos[0] = 4'd0; qos[1] = 4'd8; dat[0] = 32'hAAAA0000; dat[1] = $urandom;
    vld = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      e = (k < 16) ? 4'b0010 : 4'b0001;
      #1;
      nVec++; if (bus.oReqReady !== e) begin nErr++; $display("FAIL aging_ready[%0d] got %b exp %b", k, bus.oReqReady, e); end
      tick();
      nVec++; if (bus.oGrant !== e) begin nErr++; $display("FAIL aging_grant[%0d] got %b exp %b", k, bus.oGrant, e); end
      nVec++; if (bus.oAged !== (k == 16)) begin nErr++; $display("FAIL aging_flag[%0d] got %0b exp %0b", k, bus.oAged, (k == 16)); end
      if (k == 16) vld[0] = 1'b0; else dat[1] = $urandom;
    end
    nVec++; if (bus.oWrData !== 32'hAAAA0000) begin nErr++; $display("FAIL aging_data got %h exp aaaa0000", bus.oWrData); end
    #1;
    nVec++; if (bus.oReqReady !== 4'b0010) begin nErr++; $display("FAIL aging_resume got %b exp 0010", bus.oReqReady); end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] e;
    logic [DSIZE-1:0] held;
    do_reset();
    qos[0] = 4'd0; qos[1] = 4'd8; dat[0] = 32'hBBBB0000; dat[1] = $urandom;
    vld = 4'b0011;
    repeat (10) begin tick(); dat[1] = $urandom; end
    held = bus.oWrData;
    full = 1'b1;
    #1;
    nVec++; if (bus.oReqReady !== '0) begin nErr++; $display("FAIL bp_ready_full got %b exp 0", bus.oReqReady); end
    nVec++; if (bus.oWr !== 1'b1)     begin nErr++; $display("FAIL bp_inflight got %0b exp 1", bus.oWr); end
    for (int s = 0; s < 5; s++) begin
      tick();
      nVec++; if (bus.oWr !== 1'b0)      begin nErr++; $display("FAIL bp_stall_oWr[%0d] got %0b exp 0", s, bus.oWr); end
      nVec++; if (bus.oReqReady !== '0)  begin nErr++; $display("FAIL bp_stall_ready[%0d] got %b exp 0", s, bus.oReqReady); end
      nVec++; if (bus.oWrData !== held)  begin nErr++; $display("FAIL bp_stall_data[%0d] got %h exp %h", s, bus.oWrData, held); end
    end
    full = 1'b0;
    // req0 lost 10 before the stall; 5 more losses make it aged.
    for (int k = 1; k <= 6; k++) begin
      e = (k < 6) ? 4'b0010 : 4'b0001;
      #1;
      nVec++; if (bus.oReqReady !== e) begin nErr++; $display("FAIL bp_resume_ready[%0d] got %b exp %b", k, bus.oReqReady, e); end
      tick(); dat[1] = $urandom;
      nVec++; if (bus.oAged !== (k == 6)) begin nErr++; $display("FAIL bp_resume_aged[%0d] got %0b exp %0b", k, bus.oAged, (k == 6)); end
    end
    vld = '0;
  endtask

  task automatic test_midreset();
    do_reset();
    qos[0] = 4'd4; qos[2] = 4'd4; dat[0] = 32'h11110000; dat[2] = 32'h22220000;
    vld = 4'b0101;
    #1;
    nVec++; if (bus.oReqReady !== 4'b0001) begin nErr++; $display("FAIL mrst_first got %b exp 0001", bus.oReqReady); end
    tick(); dat[0] = 32'h11110001;
    nVec++; if (bus.oWr !== 1'b1) begin nErr++; $display("FAIL mrst_pre_oWr got %0b exp 1", bus.oWr); end
    #1 rstN = 1'b0;
    #1;
    nVec++; if (bus.oWr !== 1'b0)     begin nErr++; $display("FAIL mrst_oWr got %0b exp 0", bus.oWr); end
    nVec++; if (bus.oGrant !== '0)    begin nErr++; $display("FAIL mrst_grant got %b exp 0", bus.oGrant); end
    nVec++; if (bus.oWrData !== '0)   begin nErr++; $display("FAIL mrst_data got %h exp 0", bus.oWrData); end
    nVec++; if (bus.oReqReady !== '0) begin nErr++; $display("FAIL mrst_ready got %b exp 0", bus.oReqReady); end
    #1 rstN = 1'b1;
    #1;
    nVec++; if (bus.oReqReady !== 4'b0001) begin nErr++; $display("FAIL mrst_after_ready got %b exp 0001", bus.oReqReady); end
    tick();
    nVec++; if (bus.oGrant !== 4'b0001) begin nErr++; $display("FAIL mrst_after_grant got %b exp 0001", bus.oGrant); end
    vld = '0;
  endtask

  task automatic test_random();
    int w = -1;
    logic [NREQ-1:0] er;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      nVec++; if (bus.oWr !== expWr)         begin nErr++; $display("FAIL rand_oWr[%0d] got %0b exp %0b", c, bus.oWr, expWr); end
      nVec++; if (bus.oGrant !== expGrant)   begin nErr++; $display("FAIL rand_grant[%0d] got %b exp %b", c, bus.oGrant, expGrant); end
      nVec++; if (bus.oWrData !== expData)   begin nErr++; $display("FAIL rand_data[%0d] got %h exp %h", c, bus.oWrData, expData); end
      nVec++; if (bus.oQoS !== expQos)       begin nErr++; $display("FAIL rand_qos[%0d] got %h exp %h", c, bus.oQoS, expQos); end
      nVec++; if (bus.oAged !== expAged)     begin nErr++; $display("FAIL rand_aged[%0d] got %0b exp %0b", c, bus.oAged, expAged); end
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            vld[i] = 1'b1; dat[i] = $urandom; qos[i] = QSIZE'($urandom_range(0, 15));
          end
        end else if (i == w) begin
          if ($urandom_range(0, 1) == 0) vld[i] = 1'b0;
          else begin dat[i] = $urandom; qos[i] = QSIZE'($urandom_range(0, 15)); end
        end
      end
      full = ($urandom_range(0, 4) == 0);
      #1;
      mdlPick(w);
      er = (w < 0) ? '0 : (NREQ'(1) << w);
      nVec++; if (bus.oReqReady !== er) begin nErr++; $display("FAIL rand_ready[%0d] got %b exp %b", c, bus.oReqReady, er); end
      mdlCommit(w);
      tick();
    end
    vld = '0; full = 1'b0;
  endtask

  initial begin
    vld = '0; full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin dat[i] = '0; qos[i] = '0; end
    mdlReset();
    test_reset();
    test_single();
    test_qos_order();
    test_rr_ties();
    test_aging();
    test_backpressure();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", nVec);
    $fatal(1);
  end
endmodule

// File: doc/qos_wr_arbiter.md
# qos_wr_arbiter

- Shares the single write port of the QoS FIFO wrapper among NREQ requesters, each with its own data word and 4-bit QoS.
- Each cycle the downstream is not full, it picks one winner by:
  - aging class first,
  - then high-bandwidth QoS,
  - then numeric QoS,
  - then round-robin among ties.
- The winner's word is registered onto the wrapper's iWr/iWrData/iQoS inputs.
- Per-requester aging counters bound starvation of low-QoS traffic.

## Interface
- NREQ, 4, number of requesters (2..8)
- DSIZE, 32, data width
- QSIZE, 4, QoS width; bit 3 is the high-bandwidth flag
- AGE_MAX, 15, lost-arbitration count at which a requester becomes aged; counter width AW = clog2(AGE_MAX+1)
- iClk  in  1  single clock; all logic on posedge
- iResetn  in  1  reset, asynchronous, active-low
- iReqValid  in  NREQ  request valid, one bit per requester
- oReqReady  out  NREQ  one-hot (or zero) accept; combinational from arbitration
- iReqData  in  NREQ*DSIZE  requester i at [i*DSIZE +: DSIZE]
- iReqQoS  in  NREQ*QSIZE  requester i at [i*QSIZE +: QSIZE]
- iFull  in  1  downstream full (wrapper oFull)
- oWr  out  1  registered write strobe to wrapper
- oWrData  out  DSIZE  registered winning data
- oQoS  out  QSIZE  registered winning QoS
- oGrant  out  NREQ  registered one-hot of the requester written this cycle
- oAged  out  1  registered; the current write was won via aging

## Operation
- **Eligibility:** requester i is eligible when iReqValid[i]=1 and iFull=0. If iFull=1, nobody is eligible.
- **Priority key** per eligible requester, compared in this order (highest wins):
  - aged bit (age[i]==AGE_MAX)
  - QoS[3]
  - QoS[2:0]
- **Ties** on the full key are resolved round-robin:
  - search starts at index rr_ptr and wraps modulo NREQ;
  - the first tied candidate found wins.
- **Winner w:** oReqReady[w]=1, all other ready bits 0. A transfer occurs when valid and ready are both 1.
- **After a grant:**
  - rr_ptr ← (w+1) mod NREQ;
  - age[w] ← 0, even if it was aged.
- **Aging:**
  - A valid requester that is eligible but loses has age[i] incremented, saturating at AGE_MAX.
  - A requester that is not valid has age[i] ← 0.
  - While iFull=1, all counters and rr_ptr are frozen.
- **Requester rules:** iReqValid must not drop and data/QoS must not change before acceptance. QoS is re-sampled every cycle. Multiple aged requesters resolve by the QoS key and then round-robin.
- **Write register:** on a transfer, oWr←1, oWrData←iReqData[w], oQoS←iReqQoS[w], oGrant←onehot(w), oAged←aged bit of w. With no transfer, oWr←0, oGrant←0, oAged←0, and oWrData/oQoS hold their previous value.
- **Reset values (asynchronous):** oWr=0, oWrData=0, oQoS=0, oGrant=0, oAged=0, rr_ptr=0, all age=0. oReqReady is forced to 0 while iResetn=0.

## Timing
- Accept at cycle t (combinational ready) → oWr=1 with data at cycle t+1. Fixed latency of 1.
- Throughput is one write per cycle while iFull=0.
- iFull is used as presented, with no internal skid or credit. Overflow margin is the wrapper's responsibility.
- iFull rising at cycle t blocks acceptance in cycle t. A write already registered for t still appears.
- Reset asserted mid-stream clears outputs immediately. The first grant after release follows the rr_ptr=0 ordering.
- The arbitration path is a single combinational stage: key compare plus round-robin pick. No multicycle paths.

## Structure
- Package qos_arb_pkg:
  - QOS_HIBW_BIT=3;
  - key packing function {aged, qos[3], qos[2:0]} giving a 5-bit key;
  - constant AGE_MAX default.
- Sub-module rr_pick:
  - inputs: NREQ-bit candidate mask, rr_ptr;
  - output: one-hot winner.
  - Top level builds the mask as "eligible and key == max key".
- Top level holds the age counters, rr_ptr, the output register, and the max-key reduction.

## Test plan
- **Single request:** only req0 valid, QoS=2, data 0xA5A50001, iFull=0 → oReqReady=0001 in the same cycle; next cycle oWr=1, oWrData=0xA5A50001, oQoS=2, oGrant=0001, oAged=0.
- **Strict QoS order:** req0 QoS=1, req1 QoS=5, req2 QoS=8, all valid and held until accepted → writes in order req2, req1, req0 on three consecutive cycles.
- **Round-robin ties:** req1 and req3 both QoS=4, continuously valid with fresh data → oGrant alternates 0010, 1000, 0010, … starting with req1 after reset.
- **Aging:** req0 QoS=0 held valid; req1 QoS=8 continuously valid → req0 loses 15 cycles and is granted on the 16th, with oAged=1 on its write; then req1 resumes.
- **Backpressure:** requests pending and iFull=1 for 5 cycles → oReqReady=0, oWr=0 after the in-flight write, ages and rr_ptr unchanged; iFull→0 → the grant is the same winner as before the stall.
- **Mid-stream reset:** reset during back-to-back writes → oWr/oGrant/oWrData=0 immediately; after release, the first tie between req0 and req2 goes to req0.
